serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 179 +++++++++++++++++
 tb/tb_serial_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: one 1-bit full-adder cell processes the operands LSB
//   first, one bit per clock, so a WIDTH-bit add takes WIDTH RUN cycles.
//   The result, carry-out and overflow are registered and presented together
//   with a one-cycle done pulse.
//
// Optional feature (compile-time macro SERIAL_ADDER_SUB_EN):
//   When defined, a 'sub' input is added.  sub=1 computes a + ~b + 1 and
//   ignores ci, so co=1 means "no borrow".  When undefined, the port is
//   absent and the block always computes a + b + ci.
//
// Parameters
//   WIDTH  operand/result width in bits (2..64)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation (accepted in IDLE or DONE only)
//   a, b   in   operands, captured on the accepting edge
//   ci     in   carry-in, captured on the accepting edge
//   sub    in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   out  high in every RUN cycle
//   done   out  one-cycle result-valid pulse
//   sum    out  result, stable between done pulses
//   co     out  carry out of the MSB
//   ovf    out  two's-complement overflow
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] shr_q,   shr_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             carry_q, carry_d;
  logic             co_q,    co_d;
  logic             ovf_q,   ovf_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Operand B and carry seed as they are captured: for subtraction B is
  // inverted at capture time and the carry is seeded with 1, so the serial
  // datapath itself is always a plain adder.
  logic [WIDTH-1:0] b_op;
  logic             c_seed;

  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_op   = sub ? ~b : b;
    c_seed = sub ? 1'b1 : ci;
`else
    b_op   = b;
    c_seed = ci;
`endif
  end

  // Single full-adder cell on the bit selected by the counter.
  logic fa_a, fa_b, fa_s, fa_c;

  always_comb begin
    fa_a = a_q[cnt_q];
    fa_b = b_q[cnt_q];
    fa_s = fa_a ^ fa_b ^ carry_q;
    fa_c = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    shr_d   = shr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_op;
          carry_d = c_seed;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // New bit enters at the MSB; after WIDTH shifts bit i sits at i.
        shr_d   = {fa_s, shr_q[WIDTH-1:1]};
        carry_d = fa_c;
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = {fa_s, shr_q[WIDTH-1:1]};
          co_d    = fa_c;
          // carry_q here is the carry into the MSB.
          ovf_d   = fa_c ^ carry_q;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shr_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shr_q   <= shr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder (WIDTH=8).  The stimulus process pushes
//   the expected {sum, co, ovf} when an operation is accepted; the monitor
//   pops and compares whenever done is high, and checks the outputs stay
//   stable between done pulses.  Define SERIAL_ADDER_SUB_EN to also cover
//   subtraction.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ci    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub   = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic [W+1:0] held = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the captured operands.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic civ, input logic subv);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   f;
    exp_t         e;
    bb    = subv ? ~bv : bv;
    c     = subv ? 1'b1 : civ;
    f     = {1'b0, av} + {1'b0, bb} + (W+1)'(c);
    e.s   = f[W-1:0];
    e.co  = f[W];
    e.ovf = (av[W-1] == bb[W-1]) && (f[W-1] != av[W-1]);
    return e;
  endfunction

  // Monitor: compare on done, otherwise the result must hold still.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      held = '0;
    end else if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("co",  32'(co),  32'(e.co));
        check("ovf", 32'(ovf), 32'(e.ovf));
        held = {sum, co, ovf};
      end
    end else begin
      check("result_hold", 32'({sum, co, ovf}), 32'(held));
    end
  end

  // Issues one operation and checks its busy/done timing.  Returns at the
  // negedge of the DONE cycle with start untouched, so a following call
  // chains with no IDLE cycle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic civ, input logic subv, input bit hold,
                        input bit use_exp, input logic [W-1:0] es,
                        input logic eco, input logic eov);
    exp_t e;
    start = 1'b1;
    a     = av;
    b     = bv;
    ci    = civ;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = subv;
`endif
    @(posedge clk);
    if (use_exp) begin
      e.s = es; e.co = eco; e.ovf = eov;
    end else begin
      e = model(av, bv, civ, subv);
    end
    q.push_back(e);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (hold) begin
          a = 8'h11;
          b = 8'h11;
        end else begin
          start = 1'b0;
        end
      end
      check("busy_in_run", 32'(busy), 32'd1);
      check("done_in_run", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("done_pulse",   32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    bit           rh;

    // Reset state, checked asynchronously before any clock edge acts.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_co",   32'(co),   32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Start on the very first edge after reset release.
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1, 8'h10, 1'b0, 1'b0);
    idle(2);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 0, 1, 8'h01, 1'b1, 1'b0);
    idle(1);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1, 8'h80, 1'b0, 1'b1);
    idle(1);

    // start held high through RUN with changing operands, then chained.
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 1, 1, 8'h03, 1'b0, 1'b0);
    run_op(8'h33, 8'h44, 1'b0, 1'b0, 0, 1, 8'h77, 1'b0, 1'b0);
    idle(2);

    // Reset during bit 3 aborts with no done pulse.
    start = 1'b1; a = 8'hAA; b = 8'h55; ci = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk);
    q.push_back(model(8'hAA, 8'h55, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_co",   32'(co),   32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(W + 2);
    run_op(8'h20, 8'h22, 1'b0, 1'b0, 0, 1, 8'h42, 1'b0, 1'b0);
    idle(1);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 1, 8'hFE, 1'b0, 1'b0);
    idle(1);
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 0, 1, 8'h7F, 1'b1, 1'b1);
    idle(1);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      rh = ($urandom_range(0, 3) == 0);
      run_op(ra, rb, rc, rs, rh, 0, 8'h00, 1'b0, 1'b0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(3);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
